// File: rtl/keypad_pkg.sv
// Shared key codes, scanner FSM encoding and the 4x4 key map for the keypad front end.
// Codes are consumed unchanged by the downstream RPN stack.
package keypad_pkg;

  localparam logic [4:0] KEY_0     = 5'b00000;
  localparam logic [4:0] KEY_1     = 5'b00001;
  localparam logic [4:0] KEY_2     = 5'b00010;
  localparam logic [4:0] KEY_3     = 5'b00011;
  localparam logic [4:0] KEY_4     = 5'b00100;
  localparam logic [4:0] KEY_5     = 5'b00101;
  localparam logic [4:0] KEY_6     = 5'b00110;
  localparam logic [4:0] KEY_7     = 5'b00111;
  localparam logic [4:0] KEY_8     = 5'b01000;
  localparam logic [4:0] KEY_9     = 5'b01001;
  localparam logic [4:0] KEY_PLUS  = 5'b10000;
  localparam logic [4:0] KEY_MINUS = 5'b10001;
  localparam logic [4:0] KEY_BACKS = 5'b10010;
  localparam logic [4:0] KEY_ENTER = 5'b10011;
  localparam logic [4:0] KEY_UP    = 5'b10100;
  localparam logic [4:0] KEY_DOWN  = 5'b10101;
  localparam logic [4:0] KEY_NOP   = 5'b10110;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  // Indexed by {row, col}; element 15 (row3/col3) is listed first.
  localparam logic [15:0][4:0] KEY_MAP = {
    KEY_ENTER, KEY_DOWN, KEY_0,    KEY_UP,
    KEY_BACKS, KEY_9,    KEY_8,    KEY_7,
    KEY_MINUS, KEY_6,    KEY_5,    KEY_4,
    KEY_PLUS,  KEY_3,    KEY_2,    KEY_1
  };

  function automatic logic [1:0] col_index(input logic [3:0] col_n);
    case (col_n)
      4'b1110: col_index = 2'd0;
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      default: col_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad columns.
// Both stages reset to all-ones so an idle keypad is seen during and after reset.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce feeding the RPN stack.
// Define KEYPAD_AUTOREPEAT_EN to pulse intro low for one cycle every REPEAT_CNT held cycles.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] in_num,
  output logic       intro
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SW-1:0] DIV_MAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CNT - 1);
  // The PRESSED cycle that first sees an idle keypad counts toward release.
  localparam logic [DW-1:0] DEB_REL_START = (DEBOUNCE_CNT > 1) ? DW'(1) : '0;

  logic [3:0] col_s;

  sync2 #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [SW-1:0]   div_q, div_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [3:0]      col_q, col_d;
  logic [4:0]      in_num_q, in_num_d;
  logic            intro_q, intro_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CNT - 1);
  logic [RW-1:0]   rep_q, rep_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = |REPEAT_CNT;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    div_d    = div_q;
    deb_d    = deb_q;
    col_d    = col_q;
    in_num_d = in_num_q;
    intro_d  = intro_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d    = rep_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if ($onehot(~col_s)) begin
            col_d   = col_s;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (col_s != col_q) begin
          state_d = ST_SCAN;
          row_d   = row_q + 2'd1;
          div_d   = '0;
        end else if (deb_q == DEB_MAX) begin
          state_d  = ST_PRESSED;
          in_num_d = KEY_MAP[{row_q, col_index(col_q)}];
          intro_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d    = '0;
`endif
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (col_s == 4'b1111) begin
          state_d = ST_RELEASE;
          intro_d = 1'b1;
          deb_d   = DEB_REL_START;
`ifdef KEYPAD_AUTOREPEAT_EN
        end else if (rep_q == REP_MAX) begin
          intro_d = 1'b0;
          rep_d   = '0;
        end else begin
          intro_d = 1'b1;
          rep_d   = rep_q + 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        if (col_s == 4'b1111) begin
          if (deb_q == DEB_MAX) begin
            state_d = ST_SCAN;
            intro_d = 1'b0;
            row_d   = row_q + 2'd1;
            div_d   = '0;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SCAN;
      row_q    <= 2'd0;
      div_q    <= '0;
      deb_q    <= '0;
      col_q    <= 4'b1111;
      in_num_q <= KEY_NOP;
      intro_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      div_q    <= div_d;
      deb_q    <= deb_d;
      col_q    <= col_d;
      in_num_q <= in_num_d;
      intro_q  <= intro_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  assign row_out = ~(4'b0001 << row_q);
  assign in_num  = in_num_q;
  assign intro   = intro_q;

endmodule
